// File: rtl/nrisc_multiciclo.sv
`timescale 1ns/1ps
// nrisc_multiciclo: multi-cycle 8-bit-ISA core with req/ack instruction and data ports.
// Optional performance counters are built only when NRISC_PERF_EN is defined.
module nrisc_multiciclo #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int RESET_PC = 0
) (
  input  logic              Clock,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [7:0]        imem_rdata,
  input  logic              imem_ack,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic [ADDR_W-1:0] pc_out,
  output logic              retire
`ifdef NRISC_PERF_EN
  ,
  output logic [31:0]       cycle_count,
  output logic [31:0]       instr_count
`endif
);

  typedef enum logic [1:0] {FETCH = 2'd0, EXEC = 2'd1, MEM = 2'd2, WB = 2'd3} state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_ADDI = 3'b011;
  localparam logic [2:0] OP_LD   = 3'b100;
  localparam logic [2:0] OP_ST   = 3'b101;
  localparam logic [2:0] OP_BEQZ = 3'b110;
  localparam logic [2:0] OP_J    = 3'b111;
  localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);
  localparam int RB_IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  function automatic logic [ADDR_W-1:0] sext_addr(input logic [4:0] v, input int w);
    logic [2:0] idx;
    for (int i = 0; i < ADDR_W; i++) begin
      idx = (i < w) ? 3'(i) : 3'(w - 1);
      sext_addr[i] = v[idx];
    end
  endfunction

  function automatic logic [DATA_W-1:0] sext_data(input logic [2:0] v);
    logic [1:0] idx;
    for (int i = 0; i < DATA_W; i++) begin
      idx = (i < 3) ? 2'(i) : 2'd2;
      sext_data[i] = v[idx];
    end
  endfunction

  // Register value used as an address: truncate or zero-extend to ADDR_W.
  function automatic logic [ADDR_W-1:0] to_addr(input logic [DATA_W-1:0] v);
    logic [RB_IDX_W-1:0] idx;
    for (int i = 0; i < ADDR_W; i++) begin
      idx = (i < DATA_W) ? RB_IDX_W'(i) : '0;
      to_addr[i] = (i < DATA_W) ? v[idx] : 1'b0;
    end
  endfunction

  state_t            state, next_state;
  logic [7:0]        ir;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] regs [4];
  logic [DATA_W-1:0] result;
  logic [DATA_W-1:0] alu;
  logic [2:0]        op;
  logic [1:0]        ra_idx, rb_idx;
  logic [DATA_W-1:0] ra_val, rb_val;

  assign op     = ir[7:5];
  assign ra_idx = ir[4:3];
  assign rb_idx = ir[2:1];
  assign ra_val = regs[ra_idx];
  assign rb_val = regs[rb_idx];

  assign imem_req   = (state == FETCH) && !reset;
  assign imem_addr  = pc;
  assign pc_out     = pc;
  assign dmem_req   = (state == MEM);
  assign dmem_we    = (state == MEM) && (op == OP_ST);
  assign dmem_addr  = to_addr(rb_val);
  assign dmem_wdata = ra_val;

  // ALU result for the register-writing opcodes.
  always_comb begin
    alu = ra_val;
    case (op)
      OP_ADD:  alu = ra_val + rb_val;
      OP_SUB:  alu = ra_val - rb_val;
      OP_AND:  alu = ra_val & rb_val;
      OP_ADDI: alu = ra_val + sext_data(ir[2:0]);
      default: alu = ra_val;
    endcase
  end

  // State register.
  always_ff @(posedge Clock) begin
    if (reset) state <= FETCH;
    else       state <= next_state;
  end

  // Next-state and retire decode.
  always_comb begin
    next_state = state;
    retire     = 1'b0;
    case (state)
      FETCH: begin
        if (imem_ack) next_state = EXEC;
        else          next_state = FETCH;
      end
      EXEC: begin
        case (op)
          OP_LD, OP_ST:  next_state = MEM;
          OP_BEQZ, OP_J: begin
            next_state = FETCH;
            retire     = 1'b1;
          end
          default:       next_state = WB;
        endcase
      end
      MEM: begin
        if (dmem_ack) begin
          next_state = (op == OP_ST) ? FETCH : WB;
          retire     = (op == OP_ST);
        end else begin
          next_state = MEM;
        end
      end
      WB: begin
        next_state = FETCH;
        retire     = 1'b1;
      end
      default: next_state = FETCH;
    endcase
  end

  // Datapath: IR, PC, result latch and register file.
  always_ff @(posedge Clock) begin
    if (reset) begin
      pc     <= PC_INIT;
      ir     <= 8'h00;
      result <= '0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ack) begin
            ir <= imem_rdata;
            pc <= pc + PC_ONE;
          end
        end
        EXEC: begin
          result <= alu;
          // PC already points past this instruction, so offsets add directly.
          if (op == OP_BEQZ && ra_val == '0) pc <= pc + sext_addr({2'b00, ir[2:0]}, 3);
          else if (op == OP_J)               pc <= pc + sext_addr(ir[4:0], 5);
        end
        MEM: begin
          if (dmem_ack && op == OP_LD) result <= dmem_rdata;
        end
        WB: regs[ra_idx] <= result;
        default: ;
      endcase
    end
  end

`ifdef NRISC_PERF_EN
  // Saturating cycle and retired-instruction counters.
  always_ff @(posedge Clock) begin
    if (reset) begin
      cycle_count <= 32'd0;
      instr_count <= 32'd0;
    end else begin
      if (cycle_count != 32'hFFFF_FFFF)           cycle_count <= cycle_count + 32'd1;
      if (retire && instr_count != 32'hFFFF_FFFF) instr_count <= instr_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_nrisc_multiciclo.sv
`timescale 1ns/1ps
// Directed self-checking bench for nrisc_multiciclo with wait-state memory models.
module tb_nrisc_multiciclo;
  logic       Clock = 1'b0;
  logic       reset = 1'b1;
  logic       imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, retire;
  logic [7:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, pc_out;
`ifdef NRISC_PERF_EN
  logic [31:0] cycle_count, instr_count;
`endif

  logic [7:0] imem [256];
  logic [7:0] dmem [256];
  int   imem_delay = 0, dmem_delay = 0, icnt = 0, dcnt = 0;
  logic stray_iack = 1'b0, stray_dack = 1'b0;
  int   checks = 0, failures = 0;

  nrisc_multiciclo dut (
    .Clock(Clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .pc_out(pc_out), .retire(retire)
`ifdef NRISC_PERF_EN
    , .cycle_count(cycle_count), .instr_count(instr_count)
`endif
  );

  always #5 Clock = ~Clock;

  assign imem_rdata = imem[imem_addr];
  assign imem_ack   = stray_iack | (imem_req && icnt >= imem_delay);
  assign dmem_rdata = dmem[dmem_addr];
  assign dmem_ack   = stray_dack | (dmem_req && dcnt >= dmem_delay);

  // Wait-state counters and data-memory writes.
  always @(posedge Clock) begin
    if (reset || !imem_req || imem_ack) icnt <= 0; else icnt <= icnt + 1;
    if (reset || !dmem_req || dmem_ack) dcnt <= 0; else dcnt <= dcnt + 1;
    if (!reset && dmem_req && dmem_we && dmem_ack) dmem[dmem_addr] <= dmem_wdata;
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      imem[i] = 8'hFF;
      dmem[i] = 8'h00;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge Clock);
    #1 reset = 1'b0;
  endtask

  // Advance to the negedge of a fetch cycle with ack at address a.
  task automatic wait_fetch(input logic [7:0] a, output bit found);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge Clock);
      if (imem_req && imem_ack && imem_addr == a) found = 1'b1;
    end
  endtask

  task automatic test_reset();
    clear_mem();
    stray_iack = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    checks++;
    if (imem_req !== 1'b0 || dmem_req !== 1'b0 || dmem_we !== 1'b0 || retire !== 1'b0) begin
      failures++;
      $display("FAIL rst_ctrl got req=%b dreq=%b we=%b ret=%b exp all 0", imem_req, dmem_req, dmem_we, retire);
    end
    checks++;
    if (pc_out !== 8'h00 || imem_addr !== 8'h00 || dmem_addr !== 8'h00 || dmem_wdata !== 8'h00) begin
      failures++;
      $display("FAIL rst_outs got pc=%h ia=%h da=%h wd=%h exp 00", pc_out, imem_addr, dmem_addr, dmem_wdata);
    end
    checks++;
    if (dut.ir !== 8'h00 || dut.regs[0] !== 8'h00 || dut.regs[1] !== 8'h00 ||
        dut.regs[2] !== 8'h00 || dut.regs[3] !== 8'h00) begin
      failures++;
      $display("FAIL rst_state got ir=%h r=%h %h %h %h exp 00", dut.ir, dut.regs[0], dut.regs[1], dut.regs[2], dut.regs[3]);
    end
    @(posedge Clock);
    #1 reset = 1'b0;
    stray_iack = 1'b0;
    @(negedge Clock);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
      failures++;
      $display("FAIL rst_release got req=%b addr=%h exp 1 00", imem_req, imem_addr);
    end
  endtask

  task automatic test_zero_wait();
    logic [8:0] rpat;
    clear_mem();
    imem[0] = 8'h63; imem[1] = 8'h6F; imem[2] = 8'h02;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      @(negedge Clock);
      rpat[c] = retire;
    end
    checks++;
    if (rpat !== 9'b100_100_100) begin
      failures++;
      $display("FAIL zw_retire got=%b exp=%b", rpat, 9'b100_100_100);
    end
    @(negedge Clock);
    checks++;
    if (dut.regs[0] !== 8'h02 || dut.regs[1] !== 8'hFF) begin
      failures++;
      $display("FAIL zw_regs got r0=%h r1=%h exp 02 ff", dut.regs[0], dut.regs[1]);
    end
    checks++;
    if (pc_out !== 8'h03) begin
      failures++;
      $display("FAIL zw_pc got=%h exp=03", pc_out);
    end
  endtask

  task automatic test_imem_wait();
    bit bad;
    clear_mem();
    imem[0] = 8'h63;
    imem_delay = 4;
    do_reset();
    bad = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge Clock);
      if (imem_req !== 1'b1 || imem_addr !== 8'h00 || pc_out !== 8'h00) bad = 1'b1;
      if (dut.ir !== 8'h00) bad = 1'b1;
      if ((c == 5) !== imem_ack) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL iwait_hold got unstable req/addr/ir during wait exp stable 1/00/00");
    end
    @(negedge Clock);
    checks++;
    if (dut.ir !== 8'h63 || pc_out !== 8'h01 || imem_req !== 1'b0) begin
      failures++;
      $display("FAIL iwait_capture got ir=%h pc=%h req=%b exp 63 01 0", dut.ir, pc_out, imem_req);
    end
    imem_delay = 0;
  endtask

  task automatic test_load_store();
    bit found;
    bit bad;
    clear_mem();
    imem[0] = 8'h90; imem[1] = 8'h79; imem[2] = 8'h8E;
    imem[3] = 8'hAC; imem[4] = 8'h9C;
    dmem[0] = 8'h40; dmem[1] = 8'h5A;
    dmem_delay = 2;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge Clock);
      if (dmem_req && dmem_we) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL ls_store_seen got no store request exp one within 100 cycles");
    end
    bad = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge Clock);
      if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 8'h40 || dmem_wdata !== 8'h5A) bad = 1'b1;
      if (retire !== (k == 2)) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL ls_store_hold got req=%b we=%b a=%h d=%h exp 1 1 40 5a stable", dmem_req, dmem_we, dmem_addr, dmem_wdata);
    end
    repeat (20) @(negedge Clock);
    checks++;
    if (dmem[8'h40] !== 8'h5A) begin
      failures++;
      $display("FAIL ls_mem got=%h exp=5a", dmem[8'h40]);
    end
    checks++;
    if (dut.regs[3] !== 8'h5A || dut.regs[2] !== 8'h40 || dut.regs[1] !== 8'h5A) begin
      failures++;
      $display("FAIL ls_regs got r1=%h r2=%h r3=%h exp 5a 40 5a", dut.regs[1], dut.regs[2], dut.regs[3]);
    end
    dmem_delay = 0;
  endtask

  task automatic branch_case(input logic [7:0] at, input logic [7:0] exp, input string name);
    bit found;
    wait_fetch(at, found);
    @(negedge Clock);
    checks++;
    if (!found || retire !== 1'b1) begin
      failures++;
      $display("FAIL %s_retire got found=%b retire=%b exp 1 1", name, found, retire);
    end
    @(negedge Clock);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== exp) begin
      failures++;
      $display("FAIL %s_target got req=%b addr=%h exp 1 %h", name, imem_req, imem_addr, exp);
    end
  endtask

  task automatic test_branch();
    clear_mem();
    for (int i = 0; i < 5; i++) imem[i] = 8'h5E;
    imem[5] = 8'hC6;
    do_reset();
    branch_case(8'h05, 8'h04, "beqz_taken");
    imem[0] = 8'h61;
    do_reset();
    branch_case(8'h05, 8'h06, "beqz_not");
    clear_mem();
    do_reset();
    branch_case(8'h00, 8'h00, "jump");
  endtask

  task automatic test_wrap();
    bit found;
    clear_mem();
    imem[0] = 8'h67; imem[1] = 8'h61;
    do_reset();
    repeat (4) @(negedge Clock);
    checks++;
    if (dut.regs[0] !== 8'hFF) begin
      failures++;
      $display("FAIL wrap_neg got=%h exp=ff", dut.regs[0]);
    end
    repeat (3) @(negedge Clock);
    checks++;
    if (dut.regs[0] !== 8'h00) begin
      failures++;
      $display("FAIL wrap_add got=%h exp=00", dut.regs[0]);
    end
    clear_mem();
    imem[0] = 8'hFE; imem[255] = 8'h5E;
    do_reset();
    wait_fetch(8'hFF, found);
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL wrap_jneg got no fetch at ff exp fetch at ff");
    end
    repeat (3) @(negedge Clock);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h00 || pc_out !== 8'h00) begin
      failures++;
      $display("FAIL wrap_pc got req=%b addr=%h pc=%h exp 1 00 00", imem_req, imem_addr, pc_out);
    end
  endtask

  task automatic test_reset_mid_mem();
    bit found;
    bit bad;
    clear_mem();
    imem[0] = 8'h62; imem[1] = 8'h69; imem[2] = 8'hA2;
    dmem_delay = 10;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge Clock);
      if (dmem_req) found = 1'b1;
    end
    checks++;
    if (!found || dut.regs[0] !== 8'h02) begin
      failures++;
      $display("FAIL mid_setup got found=%b r0=%h exp 1 02", found, dut.regs[0]);
    end
    reset = 1'b1;
    @(posedge Clock);
    #1 reset = 1'b0;
    imem_delay = 20;
    stray_dack = 1'b1;
    @(negedge Clock);
    checks++;
    if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || pc_out !== 8'h00 || imem_req !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset got dreq=%b we=%b pc=%h ireq=%b exp 0 0 00 1", dmem_req, dmem_we, pc_out, imem_req);
    end
    checks++;
    if (dut.regs[0] !== 8'h00 || dut.regs[1] !== 8'h00) begin
      failures++;
      $display("FAIL mid_regs got r0=%h r1=%h exp 00 00", dut.regs[0], dut.regs[1]);
    end
    bad = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clock);
      if (retire !== 1'b0 || dmem_req !== 1'b0 || imem_req !== 1'b1 || pc_out !== 8'h00) bad = 1'b1;
    end
    stray_dack = 1'b0;
    checks++;
    if (bad || dmem[1] !== 8'h00) begin
      failures++;
      $display("FAIL mid_late_ack got disturbance=%b m1=%h exp 0 00", bad, dmem[1]);
    end
    imem_delay = 0;
    dmem_delay = 0;
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_imem_wait();
    test_load_store();
    test_branch();
    test_wrap();
    test_reset_mid_mem();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nrisc_multiciclo.md
Name: nrisc_multiciclo

Overview:
- Parametrised multi-cycle successor to the single-cycle nRisc core; same 8-bit instruction set, generalised data/address width.
- Instruction and data memories sit behind req/ack handshakes, so wait-state memories are supported.
- A state machine sequences FETCH, EXEC, MEM and WB; there is a 4-entry register file; ALU, branch and jump all sit in one block.

Parameters:
- DATA_W, 8, register/ALU/data-memory word width (>=4).
- ADDR_W, 8, PC and data-address width (>=3).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- Clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  ADDR_W  fetch address (= PC).
- imem_rdata  in  8  instruction word.
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1=store, 0=load.
- dmem_addr  out  ADDR_W  data address.
- dmem_wdata  out  DATA_W  store data.
- dmem_rdata  in  DATA_W  load data.
- dmem_ack  in  1  data access complete.
- pc_out  out  ADDR_W  current PC.
- retire  out  1  one-cycle pulse per completed instruction.

Behaviour:
- ISA fields: op=I[7:5], ra=I[4:3], rb=I[2:1], imm3=I[2:0], imm5=I[4:0]. Immediates are sign-extended to DATA_W/ADDR_W.
- Opcodes:
  - 000 ADD: ra=ra+rb.
  - 001 SUB: ra=ra-rb.
  - 010 AND: ra=ra&rb.
  - 011 ADDI: ra=ra+imm3.
  - 100 LD: ra=M[rb].
  - 101 ST: M[rb]=ra.
  - 110 BEQZ: if ra==0, PC=PC+1+imm3.
  - 111 J: PC=PC+1+imm5.
- Arithmetic wraps modulo 2^DATA_W; PC wraps modulo 2^ADDR_W.
- dmem_addr = rb truncated or zero-extended to ADDR_W.
- States: FETCH, EXEC, MEM, WB.
- FETCH:
  - imem_req=1, imem_addr=PC.
  - On imem_ack: latch IR=imem_rdata, PC<=PC+1, go to EXEC.
  - Without ack: stay in FETCH, with req and addr held stable.
- EXEC: read ra/rb, compute the result into a result register.
  - ALU ops -> WB.
  - LD/ST -> MEM.
  - BEQZ: if taken, PC<=PC+sext(imm3) (PC already incremented); retire=1; -> FETCH.
  - J: PC<=PC+sext(imm5); retire=1; -> FETCH.
- MEM:
  - dmem_req=1; dmem_we=1 for ST; dmem_wdata=ra.
  - Outputs stay stable until dmem_ack.
  - On ack: LD latches dmem_rdata and goes to WB; ST pulses retire and goes to FETCH.
- WB: write the result to ra, retire=1, -> FETCH.
- Minimum latency, with ack in the same cycle as req:
  - ALU: 3 cycles.
  - BEQZ/J: 2 cycles.
  - LD: 4 cycles.
  - ST: 3 cycles.
- ack while the matching req is low is ignored.
- Same-ra read-after-write: the WB write is visible to the next instruction's EXEC, so no hazard is possible.
- Reset (any state, including mid-handshake), effective from the next edge:
  - state=FETCH, PC=RESET_PC, IR=0, all registers=0.
  - imem_req=0 for the cycle reset is high; dmem_req=0, dmem_we=0, retire=0.
  - Any ack during reset is ignored.
- After reset: imem_req rises in the first cycle with reset low.
- Outputs on reset: pc_out=RESET_PC, imem_addr=RESET_PC, dmem_addr=0, dmem_wdata=0.

Optional Feature:
- Macro: NRISC_PERF_EN.
- Defined:
  - Adds outputs cycle_count (32b) and instr_count (32b), both reset to 0.
  - cycle_count increments every non-reset cycle.
  - instr_count increments on each retire.
  - Both saturate at 2^32-1.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Zero-wait program [ADDI r0,3; ADDI r1,-1; ADD r0,r1] -> r0=2, r1=0xFF, retire pulses at cycles 3, 6, 9 after reset release, PC=3.
- imem_ack delayed 4 cycles -> imem_req and imem_addr stay constant throughout, IR captures only on ack, PC advances by exactly 1.
- r2=0x40, r1=0x5A: ST r1,r2 then LD r3,r2 with dmem_ack delayed 2 cycles -> dmem_we=1, dmem_addr=0x40, dmem_wdata=0x5A; then r3=0x5A.
- BEQZ r0,-2 at PC=5 with r0=0 -> next fetch addr=4. With r0=1 -> next fetch addr=6. J imm5=-1 at PC=0 -> next fetch addr=0.
- Wrap: DATA_W=8, ADDI 0xFF+1 -> 0x00. PC at 0xFF plus fetch -> imem_addr 0x00.
- Reset asserted mid-MEM with dmem_req high -> next cycle dmem_req=0, PC=RESET_PC, registers=0, state FETCH; a late dmem_ack is ignored.
